// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Exports the FSM state type, default width and counter width helper.
package div_pkg;

   localparam int DIV_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_e;

   // Bit counter must hold the value WIDTH itself.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring-division iteration.
// Ports: r_i/q_i/d_i partial remainder, quotient shift reg, divisor;
//        r_o/q_o next partial remainder and next quotient shift reg.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] r_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] r_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0]   t;
   logic [WIDTH-1:0] diff;
   logic             ge;

   assign t  = {r_i, q_i[WIDTH-1]};
   assign ge = (t >= {1'b0, d_i});
   // When ge holds the true difference is below D, so the low
   // WIDTH bits of a WIDTH-bit subtract are exact.
   assign diff = t[WIDTH-1:0] - d_i;

   assign r_o = ge ? diff : t[WIDTH-1:0];
   assign q_o = {q_i[WIDTH-2:0], ge};

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Ports: clk, rst_n (async, active-low), ld load strobe, dividend,
//        divisor; quotient, remainder, busy, done pulse, div_by_zero.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = cnt_width(WIDTH);

   div_state_e       state_q, state_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] step_r;
   logic [WIDTH-1:0] step_q;

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .r_i(r_q),
      .q_i(q_q),
      .d_i(dvs_q),
      .r_o(step_r),
      .q_o(step_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dvs_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvs_q   <= dvs_d;
         q_q     <= q_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dvs_d   = dvs_q;
      q_d     = q_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         IDLE: begin
            if (ld) begin
               dvs_d = divisor;
               q_d   = dividend;
               r_d   = '0;
               cnt_d = CW'(WIDTH);
               dbz_d = 1'b0;
               if (divisor == '0) begin
                  // No iterations: report saturated quotient at once.
                  state_d = DONE;
                  quo_d   = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            q_d   = step_q;
            r_d   = step_r;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
               quo_d   = step_q;
               rem_d   = step_r;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4).
// Reference results come from plain integer / and %.
module tb_seq_divider;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ld;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_by_zero;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seq_divider #(
      .WIDTH(W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ld(ld),
      .dividend(dividend),
      .divisor(divisor),
      .quotient(quotient),
      .remainder(remainder),
      .busy(busy),
      .done(done),
      .div_by_zero(div_by_zero)
   );

   task automatic wait_idle();
      int k;
      k = 0;
      @(negedge clk);
      while (busy && k < 50) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (busy) begin
         n_fail++;
         $display("FAIL wait_idle: busy=%0b after %0d cycles, need 0", busy, k);
      end
   endtask

   // Load one division from idle and stop #1 after the edge where
   // done rises; lat counts edges after the load edge.
   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat);
      wait_idle();
      ld       = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      ld  = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      ld       = 1'b0;
      dividend = '0;
      divisor  = '0;
      #1;
      n_checks++;
      if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
         n_fail++;
         $display("FAIL reset: q=%0d r=%0d busy=%0b done=%0b dbz=%0b, need all 0",
                  quotient, remainder, busy, done, div_by_zero);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [W-1:0] ta [3];
      logic [W-1:0] tb [3];
      int lat;
      ta = '{4'd13, 4'd15, 4'd2};
      tb = '{4'd3, 4'd1, 4'd9};
      for (int i = 0; i < 3; i++) begin
         run_div(ta[i], tb[i], lat);
         n_checks++;
         if (lat !== W) begin
            n_fail++;
            $display("FAIL basic_lat %0d/%0d: got %0d, need %0d",
                     ta[i], tb[i], lat, W);
         end
         n_checks++;
         if (quotient !== W'(ta[i] / tb[i]) ||
             remainder !== W'(ta[i] % tb[i]) || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL basic %0d/%0d: q=%0d r=%0d dbz=%0b, need q=%0d r=%0d dbz=0",
                     ta[i], tb[i], quotient, remainder, div_by_zero,
                     ta[i] / tb[i], ta[i] % tb[i]);
         end
         @(posedge clk);
         #1;
         n_checks++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after: busy=%0b done=%0b, need 0 0", busy, done);
         end
      end
   endtask

   task automatic test_div_zero();
      int lat;
      run_div(4'd7, 4'd0, lat);
      n_checks++;
      if (lat !== 0) begin
         n_fail++;
         $display("FAIL dz_lat: got %0d, need 0", lat);
      end
      n_checks++;
      if (quotient !== 4'd15 || remainder !== 4'd7 || div_by_zero !== 1'b1) begin
         n_fail++;
         $display("FAIL dz: q=%0d r=%0d dbz=%0b, need q=15 r=7 dbz=1",
                  quotient, remainder, div_by_zero);
      end
      run_div(4'd6, 4'd4, lat);
      n_checks++;
      if (quotient !== 4'd1 || remainder !== 4'd2 || div_by_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL dz_clear: q=%0d r=%0d dbz=%0b, need q=1 r=2 dbz=0",
                  quotient, remainder, div_by_zero);
      end
   endtask

   task automatic test_busy_ignore();
      int ndone;
      logic [W-1:0] cq, cr;
      ndone = 0;
      cq    = '0;
      cr    = '0;
      wait_idle();
      ld       = 1'b1;
      dividend = 4'd12;
      divisor  = 4'd5;
      @(posedge clk);
      #1;
      ld = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      ld       = 1'b1;
      dividend = 4'd9;
      divisor  = 4'd2;
      @(posedge clk);
      #1;
      ld = 1'b0;
      if (done) begin
         ndone++;
         cq = quotient;
         cr = remainder;
      end
      repeat (15) begin
         @(posedge clk);
         #1;
         if (done) begin
            ndone++;
            cq = quotient;
            cr = remainder;
         end
      end
      n_checks++;
      if (ndone !== 1) begin
         n_fail++;
         $display("FAIL busy_ld_count: %0d done pulses, need 1", ndone);
      end
      n_checks++;
      if (cq !== 4'd2 || cr !== 4'd2) begin
         n_fail++;
         $display("FAIL busy_ld_result: q=%0d r=%0d, need q=2 r=2", cq, cr);
      end
   endtask

   task automatic test_reset_mid();
      int ndone;
      ndone = 0;
      wait_idle();
      ld       = 1'b1;
      dividend = 4'd13;
      divisor  = 4'd3;
      @(posedge clk);
      #1;
      ld = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: q=%0d r=%0d busy=%0b done=%0b dbz=%0b, need all 0",
                  quotient, remainder, busy, done, div_by_zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      n_checks++;
      if (ndone !== 0 || quotient !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_nodone: %0d done pulses q=%0d, need 0 and 0",
                  ndone, quotient);
      end
   endtask

   task automatic test_back_to_back();
      int c;
      int nd;
      int tdone [3];
      c  = 0;
      nd = 0;
      wait_idle();
      ld       = 1'b1;
      dividend = 4'd11;
      divisor  = 4'd2;
      while (nd < 3 && c < 40) begin
         @(posedge clk);
         #1;
         c++;
         if (done) begin
            tdone[nd] = c;
            nd++;
            n_checks++;
            if (quotient !== 4'd5 || remainder !== 4'd1) begin
               n_fail++;
               $display("FAIL b2b_result: q=%0d r=%0d, need q=5 r=1",
                        quotient, remainder);
            end
         end
      end
      ld = 1'b0;
      n_checks++;
      if (nd !== 3) begin
         n_fail++;
         $display("FAIL b2b_count: %0d done pulses, need 3", nd);
      end else begin
         n_checks++;
         if (tdone[0] !== W + 1 || tdone[1] - tdone[0] !== W + 2 ||
             tdone[2] - tdone[1] !== W + 2) begin
            n_fail++;
            $display("FAIL b2b_period: done at %0d %0d %0d, need %0d then every %0d",
                     tdone[0], tdone[1], tdone[2], W + 1, W + 2);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, eq, er;
      logic ez;
      int lat, elat;
      for (int i = 0; i < 40; i++) begin
         a = W'($urandom_range(0, 15));
         b = W'($urandom_range(0, 15));
         if (i % 8 == 0) b = '0;
         if (b == 0) begin
            eq   = '1;
            er   = a;
            ez   = 1'b1;
            elat = 0;
         end else begin
            eq   = W'(int'(a) / int'(b));
            er   = W'(int'(a) % int'(b));
            ez   = 1'b0;
            elat = W;
         end
         run_div(a, b, lat);
         n_checks++;
         if (lat !== elat || quotient !== eq || remainder !== er ||
             div_by_zero !== ez) begin
            n_fail++;
            $display("FAIL random %0d/%0d: lat=%0d q=%0d r=%0d dbz=%0b, need lat=%0d q=%0d r=%0d dbz=%0b",
                     a, b, lat, quotient, remainder, div_by_zero,
                     elat, eq, er, ez);
         end
      end
   endtask

   task automatic test_sweep();
      int lat;
      int good, bad;
      bit ok;
      logic [W-1:0] a, b;
      good = 0;
      bad  = 0;
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            a = W'(ia);
            b = W'(ib);
            run_div(a, b, lat);
            if (ib == 0) begin
               ok = (quotient === 4'd15) && (remainder === a) &&
                    (div_by_zero === 1'b1) && (lat == 0);
            end else begin
               ok = (div_by_zero === 1'b0) && (lat == W) &&
                    (int'(quotient) * ib + int'(remainder) == ia) &&
                    (int'(remainder) < ib);
            end
            n_checks++;
            if (!ok) begin
               n_fail++;
               bad++;
               $display("FAIL sweep %0d/%0d: lat=%0d q=%0d r=%0d dbz=%0b",
                        ia, ib, lat, quotient, remainder, div_by_zero);
            end else begin
               good++;
            end
         end
      end
      $display("sweep: %0d pairs ok, %0d bad", good, bad);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring binary divider: unsigned integer division, one quotient bit per clock.
- Inverse of the team's sequential shift-add multiplier; uses the same load-then-wait usage model so the two units can be driven by the same control logic and benches.
- Sits in the training arithmetic datapath.
- Result is available a fixed WIDTH+1 cycles after load.

Parameters:
WIDTH, 4, operand width in bits. Dividend, divisor, quotient and remainder are all WIDTH bits. Legal range is 2 to 16.

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst_n  in  1  asynchronous reset, active-low
ld  in  1  load strobe; sampled on the rising edge of clk; accepted only while idle
dividend  in  WIDTH  numerator; captured on an accepted ld
divisor  in  WIDTH  denominator; captured on an accepted ld
quotient  out  WIDTH  result quotient; registered
remainder  out  WIDTH  result remainder; registered
busy  out  1  high while a division is in progress; low in IDLE
done  out  1  single-cycle pulse; quotient and remainder are valid in this cycle
div_by_zero  out  1  registered flag; set together with done when the captured divisor is 0

Behaviour:
- Reset (rst_n low, asynchronous): state goes to IDLE. quotient, remainder, busy, done and div_by_zero are all 0. Internal registers are cleared.
- Reset mid-operation: the operation is aborted immediately. No done pulse is produced afterwards.
- States: IDLE, CALC, DONE.
- IDLE, ld=1 at edge E0:
  - Capture the divisor into D.
  - Q <= dividend, R <= 0, bit counter <= WIDTH, div_by_zero <= 0.
  - If divisor == 0, go to DONE with quotient <= all ones, remainder <= dividend, div_by_zero <= 1.
  - Otherwise go to CALC.
- CALC, one restoring step per edge:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]}, width WIDTH+1.
  - If T >= {1'b0, D}: R <= T - D and Q <= {Q[WIDTH-2:0], 1}.
  - Otherwise: R <= T and Q <= {Q[WIDTH-2:0], 0}.
  - Counter decrements each step. On the step where the counter is 1, go to DONE and load quotient <= final Q and remainder <= final R[WIDTH-1:0].
- DONE: done = 1 for exactly one cycle, then return to IDLE.
- Latency: for ld accepted at edge E0, CALC steps occur at E1..E_WIDTH and done is high in the cycle after edge E_WIDTH (E4 for WIDTH=4). Results are therefore stable within 6 clock edges of ld for WIDTH=4.
- Divide-by-zero path: done is high in the cycle after E0.
- busy is high in CALC and DONE, low in IDLE.
- ld while busy is ignored. It is not queued, and the captured operands are not disturbed.
- ld in the DONE cycle is ignored; a new load is accepted from IDLE only.
- quotient, remainder and div_by_zero hold their values until the next accepted ld that produces a new done, or until reset.
- Invariant when div_by_zero=0: dividend == quotient*divisor + remainder, and remainder < divisor.
- All arithmetic is unsigned. The WIDTH+1 bit compare and subtract guarantees no overflow.
- ld held high continuously: a new division starts every WIDTH+2 cycles. Each done is followed by one IDLE cycle in which ld is accepted.

Decomposition:
- Package div_pkg holds:
  - state typedef enum {IDLE, CALC, DONE}
  - default WIDTH localparam
  - counter width function clog2(WIDTH+1)
- One natural sub-module: div_step, a combinational single restoring iteration.
  - Inputs: R, Q, D.
  - Outputs: next R, next Q.
  - Instantiated once inside seq_divider.
  - Unit-testable on its own.

Test Plan:
- Reset, then ld with dividend=13, divisor=3 -> done pulse 5 edges after ld; quotient=4, remainder=1, div_by_zero=0, busy low afterwards.
- dividend=15, divisor=1 -> quotient=15, remainder=0. Then dividend=2, divisor=9 -> quotient=0, remainder=2.
- dividend=7, divisor=0 -> done in the cycle after ld; quotient=15, remainder=7, div_by_zero=1. The next valid division clears div_by_zero.
- ld dividend=12, divisor=5; after 2 cycles assert ld with dividend=9, divisor=2 while busy -> result still quotient=2, remainder=2, with exactly one done pulse. rst_n low in the middle of a division -> all outputs 0 at once and no done.
- Exhaustive sweep, 256 operand pairs for WIDTH=4:
  - each pair: ld, wait for done, assert the invariant;
  - divisor=0 cases: assert quotient=15, remainder=dividend;
  - print pass/fail count.
